// File: rtl/lstm_hist_buf.sv
// lstm_hist_buf
// Per-timestep history stack for LSTM backpropagation-through-time.
// The forward pass pushes each timestep's gate/cell/hidden vectors. The
// backward pass pops them in reverse order, along with the cell state (and
// optionally the hidden state) of the timestep directly below the popped one.
//
// Ports
//   clk                    clock
//   rst                    synchronous reset, active low
//   i_clr                  flush stack pointer and sticky flags
//   i_push / i_pop         push the six input buses / pop the top entry
//   i_a..i_h               NUM_LSTM*WIDTH input vectors
//   o_a..o_h               popped entry, registered
//   o_c_prev, o_h_prev     c / h of the entry below the popped one (0 at t=0)
//   o_valid                one-cycle pulse after an accepted pop
//   o_cnt, o_full, o_empty occupancy, registered
//   o_ovf, o_udf           sticky: push dropped / pop on empty
//
// Configuration macro: LSTM_HIST_PREVH_EN
//   defined   -> o_h_prev carries the h of the entry below the popped one
//   undefined -> o_h_prev is tied to 0 and that read path is not built
module lstm_hist_buf #(
   parameter int WIDTH    = 32,
   parameter int NUM_LSTM = 5,
   parameter int DEPTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_clr,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [NUM_LSTM*WIDTH-1:0] i_a,
   input  logic [NUM_LSTM*WIDTH-1:0] i_i,
   input  logic [NUM_LSTM*WIDTH-1:0] i_f,
   input  logic [NUM_LSTM*WIDTH-1:0] i_o,
   input  logic [NUM_LSTM*WIDTH-1:0] i_c,
   input  logic [NUM_LSTM*WIDTH-1:0] i_h,
   output logic [NUM_LSTM*WIDTH-1:0] o_a,
   output logic [NUM_LSTM*WIDTH-1:0] o_i,
   output logic [NUM_LSTM*WIDTH-1:0] o_f,
   output logic [NUM_LSTM*WIDTH-1:0] o_o,
   output logic [NUM_LSTM*WIDTH-1:0] o_c,
   output logic [NUM_LSTM*WIDTH-1:0] o_h,
   output logic [NUM_LSTM*WIDTH-1:0] o_c_prev,
   output logic [NUM_LSTM*WIDTH-1:0] o_h_prev,
   output logic                      o_valid,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt,
   output logic                      o_full,
   output logic                      o_empty,
   output logic                      o_ovf,
   output logic                      o_udf
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = NUM_LSTM*WIDTH;
   localparam int EW = 6*BW;

   // Entry layout: {a, i, f, o, c, h}, h in the low slice
   logic [EW-1:0] mem [DEPTH];

   logic [CW-1:0] sp_q, sp_d;
   logic          full_q, empty_q;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          push_acc, pop_acc;

   logic [AW-1:0] wr_idx, rd_idx, prev_idx;
   logic          prev_is_none;

   logic [BW-1:0] a_q, i_q, f_q, o_q, c_q, h_q, c_prev_q;
   logic [BW-1:0] c_prev_rd;

   assign wr_idx       = AW'(sp_q);
   assign rd_idx       = AW'(sp_q - CW'(1));
   assign prev_idx     = AW'(sp_q - CW'(2));
   assign prev_is_none = (sp_q == CW'(1));
   assign c_prev_rd    = mem[prev_idx][2*BW-1:BW];

   always_comb begin
      // A simultaneous push is always dropped: the pop wins, or on an empty
      // stack neither is served.
      pop_acc  = !i_clr && i_pop && !empty_q;
      push_acc = !i_clr && i_push && !full_q && !i_pop;
      sp_d     = sp_q;
      if (push_acc)
         sp_d = sp_q + CW'(1);
      else if (pop_acc)
         sp_d = sp_q - CW'(1);
      valid_d = pop_acc;
      ovf_d   = ovf_q | (i_push && !push_acc);
      udf_d   = udf_q | (i_pop && empty_q);
      if (i_clr) begin
         sp_d  = '0;
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   // Storage is never reset; only the pointer decides what is live.
   always_ff @(posedge clk) begin
      if (rst && push_acc)
         mem[wr_idx] <= {i_a, i_i, i_f, i_o, i_c, i_h};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sp_q     <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         a_q      <= '0;
         i_q      <= '0;
         f_q      <= '0;
         o_q      <= '0;
         c_q      <= '0;
         h_q      <= '0;
         c_prev_q <= '0;
      end else begin
         sp_q    <= sp_d;
         full_q  <= (sp_d == CW'(DEPTH));
         empty_q <= (sp_d == '0);
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         if (pop_acc) begin
            {a_q, i_q, f_q, o_q, c_q, h_q} <= mem[rd_idx];
            c_prev_q <= prev_is_none ? '0 : c_prev_rd;
         end
      end
   end

`ifdef LSTM_HIST_PREVH_EN
   logic [BW-1:0] h_prev_q;
   logic [BW-1:0] h_prev_rd;

   assign h_prev_rd = mem[prev_idx][BW-1:0];

   always_ff @(posedge clk) begin
      if (!rst)
         h_prev_q <= '0;
      else if (pop_acc)
         h_prev_q <= prev_is_none ? '0 : h_prev_rd;
   end

   assign o_h_prev = h_prev_q;
`else
   assign o_h_prev = '0;
`endif

   assign o_a      = a_q;
   assign o_i      = i_q;
   assign o_f      = f_q;
   assign o_o      = o_q;
   assign o_c      = c_q;
   assign o_h      = h_q;
   assign o_c_prev = c_prev_q;
   assign o_valid  = valid_q;
   assign o_cnt    = sp_q;
   assign o_full   = full_q;
   assign o_empty  = empty_q;
   assign o_ovf    = ovf_q;
   assign o_udf    = udf_q;

endmodule

// File: tb/tb_lstm_hist_buf.sv
module tb_lstm_hist_buf;

   localparam int WIDTH    = 32;
   localparam int NUM_LSTM = 2;
   localparam int DEPTH    = 4;
   localparam int BW       = NUM_LSTM*WIDTH;
   localparam int CW       = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          i_clr, i_push, i_pop;
   logic [BW-1:0] i_a, i_i, i_f, i_o, i_c, i_h;
   logic [BW-1:0] o_a, o_i, o_f, o_o, o_c, o_h, o_c_prev, o_h_prev;
   logic          o_valid, o_full, o_empty, o_ovf, o_udf;
   logic [CW-1:0] o_cnt;

   int total = 0;
   int bad   = 0;

   lstm_hist_buf #(.WIDTH(WIDTH), .NUM_LSTM(NUM_LSTM), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .i_clr(i_clr), .i_push(i_push), .i_pop(i_pop),
      .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o), .i_c(i_c), .i_h(i_h),
      .o_a(o_a), .o_i(o_i), .o_f(o_f), .o_o(o_o), .o_c(o_c), .o_h(o_h),
      .o_c_prev(o_c_prev), .o_h_prev(o_h_prev), .o_valid(o_valid),
      .o_cnt(o_cnt), .o_full(o_full), .o_empty(o_empty),
      .o_ovf(o_ovf), .o_udf(o_udf)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] lanes(input logic [31:0] v);
      return {v, v};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [31:0] av, input logic [31:0] cv, input logic [31:0] hv);
      i_a = lanes(av); i_i = lanes(av); i_f = lanes(av); i_o = lanes(av);
      i_c = lanes(cv); i_h = lanes(hv);
      i_push = 1'b1;
      tick();
      i_push = 1'b0;
   endtask

   task automatic do_pop();
      i_pop = 1'b1;
      tick();
      i_pop = 1'b0;
   endtask

   task automatic do_clr();
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; i_clr = 1'b0; i_push = 1'b0; i_pop = 1'b0;
      i_a = '0; i_i = '0; i_f = '0; i_o = '0; i_c = '0; i_h = '0;

      // Reset
      tick(); tick();
      chk("rst_o_a", o_a, 0);
      chk("rst_o_c", o_c, 0);
      chk("rst_o_h", o_h, 0);
      chk("rst_o_c_prev", o_c_prev, 0);
      chk("rst_o_h_prev", o_h_prev, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_empty", o_empty, 1);
      chk("rst_full", o_full, 0);
      chk("rst_ovf", o_ovf, 0);
      chk("rst_udf", o_udf, 0);
      rst = 1'b1;
      tick();

      // Three timesteps, popped in reverse
      do_push(32'h000, 32'd1, 32'h000);
      do_push(32'h100, 32'd2, 32'h100);
      do_push(32'h200, 32'd3, 32'h200);
      chk("fwd_cnt3", o_cnt, 3);
      chk("fwd_empty0", o_empty, 0);
      do_pop();
      chk("pop2_valid", o_valid, 1);
      chk("pop2_a", o_a, lanes(32'h200));
      chk("pop2_o", o_o, lanes(32'h200));
      chk("pop2_c", o_c, lanes(32'd3));
      chk("pop2_h", o_h, lanes(32'h200));
      chk("pop2_cprev", o_c_prev, lanes(32'd2));
      chk("pop2_cnt", o_cnt, 2);
      tick();
      chk("hold_valid0", o_valid, 0);
      chk("hold_c", o_c, lanes(32'd3));
      i_pop = 1'b1;
      tick();
      chk("pop1_valid", o_valid, 1);
      chk("pop1_i", o_i, lanes(32'h100));
      chk("pop1_c", o_c, lanes(32'd2));
      chk("pop1_cprev", o_c_prev, lanes(32'd1));
      tick();
      i_pop = 1'b0;
      chk("pop0_valid", o_valid, 1);
      chk("pop0_f", o_f, lanes(32'h000));
      chk("pop0_c", o_c, lanes(32'd1));
      chk("pop0_cprev", o_c_prev, 0);
      chk("pop0_cnt", o_cnt, 0);
      chk("pop0_empty", o_empty, 1);
      chk("pop0_udf", o_udf, 0);

      // Overflow
      do_push(32'h10, 32'd10, 32'h20);
      do_push(32'h11, 32'd11, 32'h21);
      do_push(32'h12, 32'd12, 32'h22);
      chk("ovf_full_pre", o_full, 0);
      do_push(32'h13, 32'd13, 32'h23);
      chk("ovf_full", o_full, 1);
      chk("ovf_cnt4", o_cnt, 4);
      chk("ovf_flag_pre", o_ovf, 0);
      do_push(32'h14, 32'd14, 32'h24);
      chk("ovf_flag", o_ovf, 1);
      chk("ovf_cnt_held", o_cnt, 4);
      do_pop();
      chk("ovf_pop_a", o_a, lanes(32'h13));
      chk("ovf_pop_c", o_c, lanes(32'd13));
      chk("ovf_pop_cprev", o_c_prev, lanes(32'd12));
      chk("ovf_sticky", o_ovf, 1);
      chk("ovf_full0", o_full, 0);
      chk("ovf_cnt3", o_cnt, 3);
      do_clr();
      chk("clr_cnt", o_cnt, 0);
      chk("clr_empty", o_empty, 1);
      chk("clr_ovf", o_ovf, 0);
      chk("clr_data_held", o_c, lanes(32'd13));
      chk("clr_valid", o_valid, 0);

      // Pop on empty
      do_pop();
      chk("udf_valid", o_valid, 0);
      chk("udf_flag", o_udf, 1);
      chk("udf_cnt", o_cnt, 0);
      chk("udf_data_held", o_c, lanes(32'd13));
      do_clr();
      chk("udf_clr", o_udf, 0);

      // Push+pop together on an empty stack
      i_push = 1'b1; i_pop = 1'b1;
      tick();
      i_push = 1'b0; i_pop = 1'b0;
      chk("pp_empty_ovf", o_ovf, 1);
      chk("pp_empty_udf", o_udf, 1);
      chk("pp_empty_cnt", o_cnt, 0);
      chk("pp_empty_valid", o_valid, 0);
      do_clr();

      // Push+pop together with two entries
      do_push(32'h50, 32'h51, 32'h52);
      do_push(32'h60, 32'h61, 32'h62);
      i_c = lanes(32'h77);
      i_push = 1'b1; i_pop = 1'b1;
      tick();
      i_push = 1'b0; i_pop = 1'b0;
      chk("pp_valid", o_valid, 1);
      chk("pp_c", o_c, lanes(32'h61));
      chk("pp_cprev", o_c_prev, lanes(32'h51));
      chk("pp_cnt", o_cnt, 1);
      chk("pp_ovf", o_ovf, 1);
      do_pop();
      chk("pp_next_c", o_c, lanes(32'h51));
      chk("pp_next_cnt", o_cnt, 0);
      do_clr();

      // Previous hidden state
      do_push(32'h1, 32'h5, 32'd7);
      do_push(32'h2, 32'h6, 32'd9);
      do_pop();
      chk("hp_h", o_h, lanes(32'd9));
      chk("hp_cprev", o_c_prev, lanes(32'h5));
`ifdef LSTM_HIST_PREVH_EN
      chk("hp_hprev", o_h_prev, lanes(32'd7));
`else
      chk("hp_hprev", o_h_prev, 0);
`endif

      // Clear has priority over a push in the same cycle
      i_clr = 1'b1; i_push = 1'b1;
      tick();
      i_clr = 1'b0; i_push = 1'b0;
      chk("clrpri_cnt", o_cnt, 0);
      chk("clrpri_ovf", o_ovf, 0);

      // Reset mid-sequence discards entries and zeroes outputs
      do_push(32'h3, 32'h8, 32'h4);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mrst_cnt", o_cnt, 0);
      chk("mrst_empty", o_empty, 1);
      chk("mrst_c", o_c, 0);
      chk("mrst_h", o_h, 0);
      do_pop();
      chk("mrst_pop_valid", o_valid, 0);
      chk("mrst_pop_udf", o_udf, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
